spi_line_fetcher: RTL and testbench
===================================

Name: spi_line_fetcher

Overview:
Parametrised next-generation SPI/QSPI line fetcher for the VGA ROM display path. On a start request it runs one complete flash read transaction: single-SPI Read (03h) or Quad Output Fast Read (6Bh) with dummy cycles. Received data is packed into a nibble-addressed line buffer. The VGA pixel path reads the buffer through a registered port, so fetch timing is decoupled from hpos, unlike the current hard-wired per-line sequence.

Parameters:
DATA_CYCLES, 136, SCLK cycles in the data phase; must be a multiple of 4 and ≥4
QSPI_DUMMY, 8, dummy SCLK cycles after address in quad mode (0 allowed)
CS_GAP, 2, minimum cycles spi_cs stays low after a transaction before done/idle; ≥1
AW, $clog2(DATA_CYCLES), buffer nibble-address width (derived; do not override)

Ports:
clk  in  1  system clock; also sources SCLK
reset  in  1  asynchronous, active-low (0 = reset)
start  in  1  request a fetch; accepted only when busy=0
quad  in  1  sampled with start: 0 = SPI 03h, 1 = QSPI 6Bh
addr  in  24  flash byte address, sampled with start
abort  in  1  synchronous abort of an in-flight transaction
busy  out  1  transaction or CS gap in progress
done  out  1  one-cycle pulse when a fetch completes normally
rd_addr  in  AW  nibble index for display read
rd_data  out  4  buffer nibble, registered
spi_cs  out  1  chip select, active HIGH (parent inverts)
spi_sclk  out  1  gated ~clk
spi_in  in  4  io[3:0] input side
spi_out0  out  1  io0 output (MOSI)
spi_dir0  out  1  io0 direction: 0 = output, 1 = input
swap  in  1  toggle display bank (double-buffer build only)

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, spi_cs=0, spi_out0=0, spi_dir0=0, rd_data=0. Gated SCLK is held low. Buffer contents are undefined. A reset mid-transaction drops CS immediately.
- FSM states and lengths: IDLE, CMD(8), ADDR(24), DUMMY(QSPI_DUMMY, quad only; skipped when 0), DATA(DATA_CYCLES), GAP(CS_GAP), then IDLE.
- Start: a start sampled on posedge k while IDLE enters CMD, and spi_cs=1 from cycle k+1. A start while busy=1 is ignored.
- spi_cs is 1 exactly during CMD, ADDR, DUMMY and DATA. Total high time is 32+DATA_CYCLES (SPI) or 32+QSPI_DUMMY+DATA_CYCLES (QSPI).
- spi_sclk = ~clk while spi_cs=1, else 0. The enable changes only on posedge clk, so SCLK is glitch-free.
- spi_out0 transmits MSB-first and changes on posedge clk: CMD[7:0] then addr[23:0]. It is 0 in all other states.
- spi_dir0 is 0 in IDLE, CMD, ADDR and GAP. In SPI mode it is 1 during DATA. In QSPI mode it is 1 from the first DUMMY cycle onward.
- Sampling: spi_in is captured on posedge spi_sclk, i.e. negedge clk.
  - SPI mode samples spi_in[1]; bits are shifted MSB-first into a nibble assembler, and every 4th bit writes nibble j = 0..DATA_CYCLES/4-1.
  - QSPI mode writes {spi_in[3:0]} to nibble j = 0..DATA_CYCLES-1, one nibble per cycle.
  - Writes land on the posedge following the sample.
- done pulses for one cycle on the last GAP cycle after a DATA phase completes. busy falls on the following cycle.
- abort while busy in CMD, ADDR, DUMMY or DATA: spi_cs=0 from the next cycle, go to GAP, done is not pulsed. Nibbles already written stay written. abort in IDLE or GAP has no effect.
- If start and abort are asserted together in IDLE, start wins.
- Read port: rd_data <= buffer[rd_addr] on each posedge (1-cycle latency). A read of a nibble being written in the same cycle returns the old value. rd_addr ≥ DATA_CYCLES returns 0.

Optional Feature:
Macro SPI_FETCH_DOUBLE_BUFFER_EN.
- Defined: two banks. Fetches write the back bank; rd_data reads the display bank. A swap pulse toggles the display bank only when busy=0; a swap while busy=1 is ignored. If swap and start occur together in IDLE, swap applies first, so the fetch targets the new back bank. The display bank is 0 after reset.
- Undefined: one bank, and the swap port is present but ignored. Reads during a fetch may return a mix of old and new data.

Test Plan:
- SPI fetch, addr=24'h000120, DATA_CYCLES=136: MOSI shows 03h then 000120h. spi_cs is high exactly 168 cycles. The flash model streams A5h repeatedly, so nibbles 0..33 read alternately 4'hA,4'h5. done pulses CS_GAP cycles after CS falls.
- QSPI fetch, addr=24'h001240: MOSI shows 6Bh then 001240h. spi_dir0 rises at cycle 32 and CS is high for 176 cycles. The model drives nibble n = n[3:0], so rd_addr=17 returns 4'h1 one cycle after rd_addr is applied.
- abort asserted at DATA cycle 10: spi_cs=0 next cycle and done is never asserted. busy falls after CS_GAP. A new start is then accepted.
- start while busy is ignored: CS length is unchanged and a single done is produced. An async reset at ADDR cycle 5 sets spi_cs=0 and busy=0 immediately, without waiting for a clock.
- Double-buffer build: fetch pattern 4'h3 then swap; fetch pattern 4'hC while reading. rd_data stays 4'h3 until the second swap, then reads 4'hC. A swap during busy leaves the bank unchanged.

Source files
------------

// File: rtl/spi_line_fetcher.sv
// spi_line_fetcher: runs one SPI (03h) or QSPI (6Bh) flash read per start
// request and packs the returned data into a nibble-addressed line buffer.
// The display path reads the buffer through a registered read port.
// Optional: define SPI_FETCH_DOUBLE_BUFFER_EN for a back/display bank pair
// toggled by swap; without it there is one bank and swap is ignored.
module spi_line_fetcher #(
    parameter int DATA_CYCLES = 136,
    parameter int QSPI_DUMMY  = 8,
    parameter int CS_GAP      = 2,
    parameter int AW          = $clog2(DATA_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          quad,
    input  logic [23:0]   addr,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic          spi_cs,
    output logic          spi_sclk,
    input  logic [3:0]    spi_in,
    output logic          spi_out0,
    output logic          spi_dir0,
    input  logic          swap
);

    localparam int         CW       = 16;
    localparam logic [7:0] CMD_SPI  = 8'h03;
    localparam logic [7:0] CMD_QSPI = 8'h6B;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          quad_q, quad_d;
    logic          ok_q, ok_d;
    logic          cs_q, cs_d;
    logic          out0_q, out0_d;
    logic          dir_q, dir_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    cmd;
    logic [3:0]    samp_q;
    logic [2:0]    asm_q;
    logic [3:0]    rd_data_q;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          rd_hit;

    assign cmd = quad ? CMD_QSPI : CMD_SPI;

    // Next-state, shift-out and done decode for the transaction sequencer.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        quad_d  = quad_q;
        ok_d    = ok_q;
        tx_d    = tx_q;
        out0_d  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_CMD;
                    quad_d  = quad;
                    ok_d    = 1'b0;
                    tx_d    = {cmd[6:0], addr, 1'b0};
                    out0_d  = cmd[7];
                end
            end
            S_CMD: begin
                out0_d = tx_q[31];
                tx_d   = {tx_q[30:0], 1'b0};
                if (cnt_q == CW'(7)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (cnt_q == CW'(23)) begin
                    state_d = (quad_q && QSPI_DUMMY > 0) ? S_DUMMY : S_DATA;
                    cnt_d   = '0;
                end else begin
                    out0_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                end
            end
            S_DUMMY: begin
                if (cnt_q == CW'(QSPI_DUMMY - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(DATA_CYCLES - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    ok_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done    = ok_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any in-flight step; ok stays clear so no done follows.
        if (abort && (state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA})) begin
            state_d = S_GAP;
            cnt_d   = '0;
            ok_d    = ok_q;
            tx_d    = tx_q;
            out0_d  = 1'b0;
        end
        cs_d  = state_d inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
        dir_d = state_d inside {S_DUMMY, S_DATA};
    end

    // Sequencer state and registered pad outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quad_q  <= 1'b0;
            ok_q    <= 1'b0;
            cs_q    <= 1'b0;
            out0_q  <= 1'b0;
            dir_q   <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quad_q  <= quad_d;
            ok_q    <= ok_d;
            cs_q    <= cs_d;
            out0_q  <= out0_d;
            dir_q   <= dir_d;
            tx_q    <= tx_d;
        end
    end

    // Capture the io lines on the rising SCLK edge (falling clk).
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) samp_q <= '0;
        else        samp_q <= spi_in;
    end

    // Single-SPI nibble assembler: keeps the three previous io1 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                asm_q <= '0;
        else if (state_q == S_DATA) asm_q <= {asm_q[1:0], samp_q[1]};
    end

    assign wr_en   = (state_q == S_DATA) && (quad_q || cnt_q[1:0] == 2'b11);
    assign wr_addr = quad_q ? cnt_q[AW-1:0] : cnt_q[AW+1:2];
    assign wr_data = quad_q ? samp_q : {asm_q, samp_q[1]};
    assign rd_hit  = int'(rd_addr) < DATA_CYCLES;

`ifdef SPI_FETCH_DOUBLE_BUFFER_EN
    logic       disp_q;
    logic [3:0] mem [2][DATA_CYCLES];

    // Display bank select; only flips while no fetch is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              disp_q <= 1'b0;
        else if (swap && !busy)  disp_q <= ~disp_q;
    end

    // Fetches fill the bank that is not on display.
    // NOTE: the line buffer is deliberately not reset; contents are undefined until fetched.
    always_ff @(posedge clk) begin
        if (wr_en) mem[~disp_q][wr_addr] <= wr_data;
    end

    // Registered display read; out-of-range indices return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_hit ? mem[disp_q][rd_addr] : 4'h0;
    end
`else
    logic       unused_swap;
    logic [3:0] mem [DATA_CYCLES];

    assign unused_swap = swap;

    // Fetches write straight into the single displayed bank.
    // NOTE: the line buffer is deliberately not reset; contents are undefined until fetched.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered display read; out-of-range indices return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_hit ? mem[rd_addr] : 4'h0;
    end
`endif

    assign busy     = (state_q != S_IDLE);
    assign spi_cs   = cs_q;
    assign spi_sclk = cs_q & ~clk;
    assign spi_out0 = out0_q;
    assign spi_dir0 = dir_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_line_fetcher.sv
// Directed bench for spi_line_fetcher with a behavioural flash model and an
// expected-value queue for MOSI bits and read-port results.
module tb_spi_line_fetcher;

    localparam int DC  = 136;
    localparam int QD  = 8;
    localparam int GAP = 2;
    localparam int AW  = $clog2(DC);

    logic          clk;
    logic          reset;
    logic          start;
    logic          quad;
    logic [23:0]   addr;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic          spi_cs;
    logic          spi_sclk;
    logic [3:0]    spi_in;
    logic          spi_out0;
    logic          spi_dir0;
    logic          swap;

    spi_line_fetcher #(.DATA_CYCLES(DC), .QSPI_DUMMY(QD), .CS_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .quad(quad), .addr(addr),
        .abort(abort), .busy(busy), .done(done), .rd_addr(rd_addr),
        .rd_data(rd_data), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_in(spi_in), .spi_out0(spi_out0), .spi_dir0(spi_dir0), .swap(swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // Flash model: counts CS-high cycles and drives data after the header.
    logic       fl_quad = 1'b0;
    logic       fl_fill = 1'b0;
    logic [3:0] fl_val  = 4'h0;
    logic [7:0] fl_byte = 8'hA5;
    int         fl_cyc  = 0;
    int         fl_d;
    always @(posedge clk) begin
        #1;
        if (spi_cs) begin
            fl_d = fl_cyc - 32 - (fl_quad ? QD : 0);
            if (fl_d < 0)     spi_in = 4'h0;
            else if (fl_quad) spi_in = fl_fill ? fl_val : 4'(fl_d);
            else              spi_in = {2'b00, fl_byte[7 - (fl_d % 8)], 1'b0};
            fl_cyc++;
        end else begin
            fl_cyc = 0;
            spi_in = 4'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed %0h expected queued value", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Make the most recent fetch visible on the read port.
    task automatic publish();
`ifdef SPI_FETCH_DOUBLE_BUFFER_EN
        swap = 1'b1;
        step();
        swap = 1'b0;
`endif
    endtask

    task automatic read_check(input int a, input logic [3:0] exp);
        rd_addr = AW'(a);
        push_exp($sformatf("rd[%0d]", a), 32'(exp));
        step();
        pop_check(32'(rd_data));
    endtask

    // Full transaction with MOSI, CS length, direction, gap and done checks.
    task automatic run_fetch(input logic q, input logic [23:0] a, input int abort_at,
                             input bit busy_start);
        int          dummy, cs_len, gap, n_done, done_at, exp_len;
        logic [31:0] word;
        dummy = q ? QD : 0;
        word  = {(q ? 8'h6B : 8'h03), a};
        for (int i = 0; i < 32; i++) push_exp("mosi", 32'(word[31-i]));
        fl_quad = q;
        quad    = q;
        addr    = a;
        start   = 1'b1;
        step();
        start  = 1'b0;
        cs_len = 0;
        while (spi_cs && cs_len < 1000) begin
            abort = 1'b0;
            start = 1'b0;
            if (cs_len < 32)  pop_check(32'(spi_out0));
            if (cs_len == 31) check("dir0_addr_end", spi_dir0, 0);
            if (cs_len == 32) check("dir0_rise", spi_dir0, 1);
            if (abort_at >= 0 && cs_len == 32 + dummy + abort_at) abort = 1'b1;
            if (busy_start && cs_len == 40) start = 1'b1;
            cs_len++;
            step();
        end
        abort   = 1'b0;
        start   = 1'b0;
        exp_len = (abort_at >= 0) ? 33 + dummy + abort_at : 32 + dummy + DC;
        check("cs_len", cs_len, exp_len);
        gap     = 0;
        n_done  = 0;
        done_at = -1;
        while (busy && gap < 50) begin
            if (done) begin
                n_done++;
                done_at = gap + 1;
            end
            gap++;
            step();
        end
        check("gap_len", gap, GAP);
        check("done_count", n_done, (abort_at >= 0) ? 0 : 1);
        if (abort_at < 0) check("done_pos", done_at, GAP);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        quad    = 1'b0;
        addr    = '0;
        abort   = 1'b0;
        rd_addr = '0;
        swap    = 1'b0;
        spi_in  = 4'h0;

        // Reset values.
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", spi_cs, 0);
        check("rst_sclk", spi_sclk, 0);
        check("rst_out0", spi_out0, 0);
        check("rst_dir0", spi_dir0, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        step();

        // Single-SPI fetch: A5h stream gives alternating A/5 nibbles.
        run_fetch(1'b0, 24'h000120, -1, 1'b0);
        publish();
        for (int j = 0; j < DC / 4; j++) read_check(j, (j % 2 == 0) ? 4'hA : 4'h5);
        read_check(200, 4'h0);

        // Quad fetch: nibble n holds n[3:0].
        run_fetch(1'b1, 24'h001240, -1, 1'b0);
        publish();
        read_check(17, 4'h1);
        read_check(0, 4'h0);
        read_check(135, 4'h7);
        read_check(136, 4'h0);

        // Abort at DATA cycle 10: no done, earlier nibbles kept.
        run_fetch(1'b0, 24'h000200, 10, 1'b0);
`ifndef SPI_FETCH_DOUBLE_BUFFER_EN
        read_check(0, 4'hA);
        read_check(1, 4'h5);
        read_check(2, 4'h2);
`endif

        // New start accepted after abort; a start while busy is ignored.
        run_fetch(1'b1, 24'h00ABCD, -1, 1'b1);
        publish();
        read_check(17, 4'h1);
        read_check(100, 4'h4);

        // SCLK gating and asynchronous reset during ADDR cycle 5.
        quad    = 1'b0;
        fl_quad = 1'b0;
        addr    = 24'h000300;
        start   = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        #1;
        check("sclk_high", spi_sclk, 1);
        step();
        check("sclk_low", spi_sclk, 0);
        for (int i = 0; i < 12; i++) step();
        check("cs_before_rst", spi_cs, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_cs", spi_cs, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sclk", spi_sclk, 0);
        #3;
        reset = 1'b1;
        step();
        check("post_rst_busy", busy, 0);

`ifdef SPI_FETCH_DOUBLE_BUFFER_EN
        // Double buffer: display stays on the old line until swapped.
        fl_fill = 1'b1;
        fl_val  = 4'h3;
        run_fetch(1'b1, 24'h000000, -1, 1'b0);
        publish();
        read_check(5, 4'h3);
        fl_val = 4'hC;
        quad   = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rd_addr = AW'(5);
            swap    = (i == 20);
            push_exp("db_during_fetch", 32'h3);
            step();
            pop_check(32'(rd_data));
        end
        swap = 1'b0;
        wait_idle();
        read_check(5, 4'h3);
        publish();
        read_check(5, 4'hC);
        fl_fill = 1'b0;
`endif

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
